// File: rtl/result_fifo_if.sv
// Handshake bundle between the bfloat16 adder, result_fifo and the co-processor read-back logic.
// The slave modport is the FIFO side. The master modport is the producer/consumer side.
`default_nettype none
interface result_fifo_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_stb;
    logic             in_busy;
    logic [WIDTH-1:0] out_data;
    logic             out_stb;
    logic             out_busy;
    logic             flush;
    logic [LVL_W-1:0] level;
    logic             nan_seen;

    modport slave (
        input  in_data,
        input  in_stb,
        output in_busy,
        output out_data,
        output out_stb,
        input  out_busy,
        input  flush,
        output level,
        output nan_seen
    );

    modport master (
        output in_data,
        output in_stb,
        input  in_busy,
        input  out_data,
        input  out_stb,
        output out_busy,
        output flush,
        input  level,
        input  nan_seen
    );
endinterface
`default_nettype wire

// File: rtl/result_fifo.sv
// result_fifo: in-order buffer of bfloat16 adder results with STB/BUSY handshake on both sides.
// Define RESULT_FIFO_NAN_FLAG_EN to build the sticky NaN detector behind nan_seen.
`default_nettype none
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    result_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] cnt_q;
    logic [LVL_W-1:0] cnt_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             full_q;
    logic             nonempty_q;

    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] rd_ptr_inc_s;

    // Handshake qualifiers use only registered status, so in_busy never sees out_busy or in_stb.
    assign push_s       = bus.in_stb & ~full_q;
    assign pop_s        = nonempty_q & ~bus.out_busy;
    assign rd_ptr_inc_s = rd_ptr_q + PTR_ONE;

    // Next pointers, occupancy and head word; flush overrides any transfer in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        if (bus.flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            cnt_d    = LVL_ZERO;
            head_d   = head_q;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_inc_s;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + LVL_ONE;
                2'b01:   cnt_d = cnt_q - LVL_ONE;
                default: cnt_d = cnt_q;
            endcase

            // Head register mirrors mem[rd_ptr]; a word entering an empty (or just-drained) queue
            // becomes the head directly.
            if (pop_s && (cnt_q != LVL_ONE)) begin
                head_d = mem_q[rd_ptr_inc_s];
            end else if (push_s && (pop_s || (cnt_q == LVL_ZERO))) begin
                head_d = bus.in_data;
            end else begin
                head_d = head_q;
            end
        end
    end

    // Control and status flops; status flags are computed from cnt_d so they come straight out of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            cnt_q      <= LVL_ZERO;
            head_q     <= {WIDTH{1'b0}};
            full_q     <= 1'b0;
            nonempty_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            full_q     <= (cnt_d == LVL_FULL);
            nonempty_q <= (cnt_d != LVL_ZERO);
        end
    end

    // Storage array; contents survive flush and reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_s && !bus.flush) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_busy  = full_q;
    assign bus.out_stb  = nonempty_q;
    assign bus.out_data = head_q;
    assign bus.level    = cnt_q;

`ifdef RESULT_FIFO_NAN_FLAG_EN
    function automatic logic is_bf16_nan(input logic [14:0] word);
        return (word[14:7] == 8'hFF) && (word[6:0] != 7'd0);
    endfunction

    logic nan_seen_q;

    // Sticky NaN indicator; infinities (zero mantissa) do not set it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_seen_q <= 1'b0;
        end else if (bus.flush) begin
            nan_seen_q <= 1'b0;
        end else if (push_s && is_bf16_nan(bus.in_data[14:0])) begin
            nan_seen_q <= 1'b1;
        end else begin
            nan_seen_q <= nan_seen_q;
        end
    end

    assign bus.nan_seen = nan_seen_q;
`else
    assign bus.nan_seen = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_fifo.sv
// Directed testbench for result_fifo: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
`timescale 1ns/1ps
module tb_result_fifo;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
`ifdef RESULT_FIFO_NAN_FLAG_EN
    localparam bit NAN_EN = 1'b1;
`else
    localparam bit NAN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    result_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_nan_m(input logic [15:0] w);
        return (w[14:7] == 8'hFF) && (w[6:0] != 7'd0);
    endfunction

    // Reference model: a plain queue of words with the accept/take rules applied at each edge.
    logic [WIDTH-1:0] mq[$];
    bit               nan_m = 1'b0;
    bit               m_acc;
    bit               m_take;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            nan_m = 1'b0;
        end else begin
            m_acc  = bus.in_stb && (mq.size() < DEPTH);
            m_take = (mq.size() > 0) && !bus.out_busy;
            if (bus.flush) begin
                mq.delete();
                nan_m = 1'b0;
            end else begin
                if (m_take) void'(mq.pop_front());
                if (m_acc) begin
                    mq.push_back(bus.in_data);
                    if (NAN_EN && is_nan_m(bus.in_data)) nan_m = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_level", 32'(bus.level), 32'(mq.size()));
            chk("m_out_stb", 32'(bus.out_stb), 32'(mq.size() != 0));
            chk("m_in_busy", 32'(bus.in_busy), 32'(mq.size() == DEPTH));
            chk("m_nan_seen", 32'(bus.nan_seen), 32'(nan_m));
            if (mq.size() != 0) chk("m_out_data", 32'(bus.out_data), 32'(mq[0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [15:0] w);
        bus.in_data = w;
        bus.in_stb  = 1'b1;
        cyc();
        bus.in_stb  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_data  = 16'h0000;
        bus.in_stb   = 1'b0;
        bus.out_busy = 1'b0;
        bus.flush    = 1'b0;
        rst_n        = 1'b1;
        #2;
        rst_n  = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset then idle
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_in_busy", 32'(bus.in_busy), 32'd0);
        chk("rst_out_stb", 32'(bus.out_stb), 32'd0);
        chk("rst_nan", 32'(bus.nan_seen), 32'd0);
        repeat (3) cyc();
        chk("idle_level", 32'(bus.level), 32'd0);

        // Single transfer
        push1(16'h3F80);
        chk("single_stb", 32'(bus.out_stb), 32'd1);
        chk("single_data", 32'(bus.out_data), 32'h3F80);
        chk("single_level", 32'(bus.level), 32'd1);
        cyc();
        chk("single_drain", 32'(bus.level), 32'd0);

        // Fill and block
        bus.out_busy = 1'b1;
        push1(16'h4000);
        push1(16'h4040);
        push1(16'h4080);
        push1(16'h40A0);
        chk("fill_level", 32'(bus.level), 32'd4);
        chk("fill_busy", 32'(bus.in_busy), 32'd1);
        bus.in_data = 16'h40C0;
        bus.in_stb  = 1'b1;
        cyc();
        cyc();
        chk("blocked_level", 32'(bus.level), 32'd4);
        chk("blocked_head", 32'(bus.out_data), 32'h4000);
        bus.out_busy = 1'b0;
        cyc();
        chk("rel_level", 32'(bus.level), 32'd3);
        chk("rel_busy", 32'(bus.in_busy), 32'd0);
        chk("rel_head1", 32'(bus.out_data), 32'h4040);
        cyc();
        bus.in_stb = 1'b0;
        chk("rel_level2", 32'(bus.level), 32'd3);
        chk("rel_head2", 32'(bus.out_data), 32'h4080);
        cyc();
        chk("rel_head3", 32'(bus.out_data), 32'h40A0);
        cyc();
        chk("rel_head4", 32'(bus.out_data), 32'h40C0);
        cyc();
        chk("rel_empty", 32'(bus.level), 32'd0);

        // Wrap-around with concurrent push/pop
        for (int i = 1; i <= 12; i++) begin
            bus.in_data = 16'(i);
            bus.in_stb  = 1'b1;
            cyc();
            chk("wrap_data", 32'(bus.out_data), 32'(i));
            chk("wrap_level", 32'(bus.level), 32'd1);
        end
        bus.in_stb = 1'b0;
        cyc();
        chk("wrap_empty", 32'(bus.level), 32'd0);

        // Flush priority
        bus.out_busy = 1'b1;
        push1(16'hAAAA);
        push1(16'hBBBB);
        push1(16'hCCCC);
        chk("pre_flush_level", 32'(bus.level), 32'd3);
        bus.in_data = 16'h1234;
        bus.in_stb  = 1'b1;
        bus.flush   = 1'b1;
        cyc();
        bus.in_stb  = 1'b0;
        bus.flush   = 1'b0;
        chk("flush_level", 32'(bus.level), 32'd0);
        chk("flush_stb", 32'(bus.out_stb), 32'd0);
        bus.out_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("flush_stays_empty", 32'(bus.out_stb), 32'd0);
        end

        // NaN flag
        push1(16'h7F80);
        chk("inf_no_nan", 32'(bus.nan_seen), 32'd0);
        push1(16'hFFC0);
        chk("nan_set", 32'(bus.nan_seen), 32'(NAN_EN));
        push1(16'h3F80);
        cyc();
        chk("nan_sticky", 32'(bus.nan_seen), 32'(NAN_EN));
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("nan_flush", 32'(bus.nan_seen), 32'd0);

        // Asynchronous reset mid-operation, then push on the first edge after release
        bus.out_busy = 1'b1;
        push1(16'h1111);
        push1(16'h2222);
        chk("pre_rst_level", 32'(bus.level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", 32'(bus.level), 32'd0);
        chk("async_rst_stb", 32'(bus.out_stb), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push1(16'h5555);
        chk("post_rst_level", 32'(bus.level), 32'd1);
        chk("post_rst_data", 32'(bus.out_data), 32'h5555);
        bus.out_busy = 1'b0;
        cyc();
        chk("post_rst_drain", 32'(bus.level), 32'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
